// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB colour sequencer: FSM states,
// 2-bit PWM duty codes and the fixed 8-entry colour table.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } seq_state_t;

  // Duty codes understood by the downstream PWM controllers
  localparam logic [1:0] OFF = 2'd0;  // off
  localparam logic [1:0] D12 = 2'd1;  // 12.5 %
  localparam logic [1:0] D25 = 2'd2;  // 25 %
  localparam logic [1:0] D50 = 2'd3;  // 50 %

  localparam int NUM_ENTRIES = 8;

  function automatic logic [5:0] bgr(input logic [1:0] b, input logic [1:0] g,
                                     input logic [1:0] r);
    return {b, g, r};
  endfunction

  // Packed so that COLOR_TABLE[i] selects entry i; entry 7 is listed first.
  localparam logic [NUM_ENTRIES-1:0][5:0] COLOR_TABLE = {
    bgr(OFF, OFF, OFF),  // 7
    bgr(D50, D50, D50),  // 6
    bgr(D50, OFF, D50),  // 5
    bgr(D50, OFF, OFF),  // 4
    bgr(D50, D50, OFF),  // 3
    bgr(OFF, D50, OFF),  // 2
    bgr(OFF, D50, D50),  // 1
    bgr(OFF, OFF, D50)   // 0
  };

endpackage

// File: rtl/rgb_sequencer_hold_timer.sv
// Per-entry hold counter: counts enabled ticks and flags the last tick of an
// entry. A limit of 0 behaves as 1; a count already past the limit is terminal.
module hold_timer #(
  parameter int TICK_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [TICK_W-1:0] limit,
  output logic              terminal
);

  logic [TICK_W-1:0] count_reg;
  logic [TICK_W-1:0] last_count;

  assign last_count = (limit == '0) ? '0 : limit - TICK_W'(1);
  // >= rather than == so a shortened limit mid-entry advances on the next tick
  assign terminal   = (count_reg >= last_count);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= terminal ? '0 : count_reg + TICK_W'(1);
    end
  end

endmodule

// File: rtl/rgb_sequencer.sv
// Steps through the fixed colour table, holding each entry for hold_ticks
// prescaler ticks; supports pause, looping and a done pulse on completion.
module rgb_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int TICK_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              pause,
  input  logic              loop,
  input  logic [TICK_W-1:0] hold_ticks,
  output logic [5:0]        duty_rgb,
  output logic [2:0]        index,
  output logic              busy,
  output logic              done
);

  seq_state_t state_reg;
  logic [2:0] index_reg;
  logic [5:0] duty_reg;
  logic       busy_reg;
  logic       done_reg;

  logic       timer_enable;
  logic       timer_clear;
  logic       terminal;
  logic [2:0] index_next;

  // Pause wins over a coincident tick, so the counter only moves in RUN without pause
  assign timer_enable = (state_reg == ST_RUN) && !pause && tick;
  assign timer_clear  = (state_reg == ST_IDLE);
  assign index_next   = index_reg + 3'd1;

  hold_timer #(
    .TICK_W(TICK_W)
  ) u_hold_timer (
    .clock    (clock),
    .reset    (reset),
    .enable   (timer_enable),
    .clear    (timer_clear),
    .limit    (hold_ticks),
    .terminal (terminal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      index_reg <= 3'd0;
      duty_reg  <= 6'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_RUN;
            index_reg <= 3'd0;
            duty_reg  <= COLOR_TABLE[0];
            busy_reg  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_reg <= ST_PAUSED;
          end else if (tick && terminal) begin
            if (index_reg == 3'd7 && !loop) begin
              state_reg <= ST_IDLE;
              index_reg <= 3'd0;
              duty_reg  <= 6'd0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              // 3-bit increment wraps 7 -> 0 when looping
              index_reg <= index_next;
              duty_reg  <= COLOR_TABLE[index_next];
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_reg <= ST_RUN;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          index_reg <= 3'd0;
          duty_reg  <= 6'd0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign duty_rgb = duty_reg;
  assign index    = index_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule
